// File: rtl/dma_descriptor_queue_pkg.sv
// Shared constants for the DMA descriptor queue: register map, status/control bits, FSM encoding, descriptor layout.
// No logic and no latency; no handshake of its own.
package dma_queue_pkg;

    localparam int DESC_W = 62;

    localparam logic [1:0] REG_TARGET = 2'd0;
    localparam logic [1:0] REG_RDADDR = 2'd1;
    localparam logic [1:0] REG_LEN    = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_BUSY     = 8;
    localparam int ST_ERR      = 9;
    localparam int ST_OVF      = 10;
    localparam int ST_EN       = 11;
    localparam int ST_IRQEN    = 12;
    localparam int ST_DONE_LSB = 16;

    localparam int CTL_EN    = 0;
    localparam int CTL_ABORT = 1;
    localparam int CTL_IRQEN = 2;
    localparam int CTL_CLR   = 3;

    localparam int WAIT_START_CYCLES = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_START,
        S_BUSY,
        S_CHECK,
        S_HALT
    } dma_state_e;

    typedef struct packed {
        logic [31:0] target;
        logic [19:0] rd_addr;
        logic [9:0]  len;
    } desc_t;

endpackage

// File: rtl/dma_descriptor_queue_if.sv
// Wishbone classic slave bundle for the descriptor queue register port.
// Single-cycle registered ack; no wait states, err/rty never raised.
interface dma_descriptor_queue_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;
    logic        wbs_err_o;
    logic        wbs_rty_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
        input  wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
        output wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o
    );
endinterface

// File: rtl/dma_descriptor_queue_fifo.sv
// First-word-fall-through descriptor FIFO with occupancy count and flush.
// Head visible combinationally; a push while full is refused unless a pop happens the same cycle.
module desc_fifo
    import dma_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = DESC_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [W-1:0]           dat_i,
    output logic [W-1:0]           dat_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign do_push = push_i & ~flush_i & (~full_o | do_pop);
    assign dat_o   = mem_q[rp_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wp_q] <= dat_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + AW'(1);
            if (do_pop)  rp_q <= rp_q + AW'(1);
            cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
endmodule

// File: rtl/dma_descriptor_queue.sv
// Wishbone-programmed descriptor queue feeding a DMA engine: one launch per descriptor, status/irq tracking.
// Ack one cycle after strobe; launch two cycles after enable with a non-empty queue; pushes into a full queue are dropped.
module dma_descriptor_queue
    import dma_queue_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    dma_descriptor_queue_if.slave wbs,
    output logic [31:0]           target_begin_address,
    output logic [19:0]           rd_address,
    output logic [9:0]            transfer_length,
    output logic                  begin_dma,
    output logic                  abort_dma,
    input  logic                  dma_active,
    input  logic                  dma_complete_ok,
    input  logic                  dma_err,
    output logic                  irq_o
);
    localparam int CW = $clog2(QDEPTH) + 1;

    dma_state_e  state_q, state_d;
    logic [1:0]  wcnt_q, wcnt_d;
    logic        ack_q, abort_q, en_q, irqen_q, err_q, ovf_q;
    logic [31:0] rdat_q, tgt_q;
    logic [19:0] rda_q;
    logic [9:0]  len_q;
    logic [7:0]  done_q;
    desc_t       desc_q, fifo_dout;

    logic          acc, wr, push, ctrl_wr, abort_req, clr_req, ovf_set;
    logic          pop, fsm_err, fsm_ok, fsm_dis, busy;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [1:0]    sel;
    logic [31:0]   status, rd_mux;
    logic          unused_adr;

    assign sel        = wbs.wbs_adr_i[3:2];
    assign unused_adr = ^wbs.wbs_adr_i[1:0];
    assign acc        = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q;
    assign wr         = acc & wbs.wbs_we_i;
    assign push       = wr && (sel == REG_LEN);
    assign ctrl_wr    = wr && (sel == REG_CTRL);
    assign abort_req  = ctrl_wr & wbs.wbs_dat_i[CTL_ABORT];
    assign clr_req    = ctrl_wr & wbs.wbs_dat_i[CTL_CLR];
    assign ovf_set    = push & fifo_full & ~pop & ~abort_req;

    desc_fifo #(.DEPTH(QDEPTH), .W(DESC_W)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (abort_req),
        .dat_i   ({tgt_q, rda_q, wbs.wbs_dat_i[9:0]}),
        .dat_o   (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign busy   = (state_q != S_IDLE) && (state_q != S_HALT);
    assign status = {8'h00, done_q, 3'b000, irqen_q, en_q, ovf_q, err_q, busy, 3'b000, 5'(fifo_count)};

    always_comb begin
        rd_mux = status;
        case (sel)
            REG_TARGET: rd_mux = tgt_q;
            REG_RDADDR: rd_mux = {12'h000, rda_q};
            REG_LEN:    rd_mux = {22'h000000, len_q};
            default:    rd_mux = status;
        endcase
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        pop     = 1'b0;
        fsm_err = 1'b0;
        fsm_ok  = 1'b0;
        fsm_dis = 1'b0;
        case (state_q)
            S_IDLE: if (en_q && !fifo_empty) begin
                pop     = 1'b1;
                state_d = S_LAUNCH;
            end
            S_LAUNCH: begin
                wcnt_d  = '0;
                state_d = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (dma_active) begin
                    state_d = S_BUSY;
                end else if (wcnt_q == 2'(WAIT_START_CYCLES - 1)) begin
                    fsm_err = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            S_BUSY: if (!dma_active) state_d = S_CHECK;
            S_CHECK: begin
                if (dma_complete_ok && !dma_err) begin
                    fsm_ok  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    fsm_err = 1'b1;
                    fsm_dis = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_HALT: if (clr_req) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort wins over everything and leaves counters and stickies as they were.
        if (abort_req) begin
            state_d = S_IDLE;
            pop     = 1'b0;
            fsm_err = 1'b0;
            fsm_ok  = 1'b0;
            fsm_dis = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            ack_q   <= 1'b0;
            abort_q <= 1'b0;
            rdat_q  <= '0;
            tgt_q   <= '0;
            rda_q   <= '0;
            len_q   <= '0;
            en_q    <= 1'b0;
            irqen_q <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= '0;
            desc_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            ack_q   <= acc;
            abort_q <= abort_req;
            if (acc) rdat_q <= rd_mux;
            if (wr && sel == REG_TARGET) tgt_q <= wbs.wbs_dat_i;
            if (wr && sel == REG_RDADDR) rda_q <= wbs.wbs_dat_i[19:0];
            if (push) len_q <= wbs.wbs_dat_i[9:0];
            if (ctrl_wr) begin
                en_q    <= wbs.wbs_dat_i[CTL_EN];
                irqen_q <= wbs.wbs_dat_i[CTL_IRQEN];
            end
            if (fsm_dis) en_q <= 1'b0;
            if (pop) desc_q <= fifo_dout;
            if (clr_req) begin
                err_q  <= 1'b0;
                ovf_q  <= 1'b0;
                done_q <= '0;
            end else begin
                if (fsm_err) err_q <= 1'b1;
                if (ovf_set) ovf_q <= 1'b1;
                if (fsm_ok)  done_q <= done_q + 8'd1;
            end
        end
    end

    assign wbs.wbs_dat_o = rdat_q;
    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_err_o = 1'b0;
    assign wbs.wbs_rty_o = 1'b0;

    assign target_begin_address = desc_q.target;
    assign rd_address           = desc_q.rd_addr;
    assign transfer_length      = desc_q.len;
    assign begin_dma            = (state_q == S_LAUNCH);
    assign abort_dma            = abort_q;
    assign irq_o = (err_q | (fifo_empty & (state_q == S_IDLE) & (done_q != 8'd0))) & irqen_q;
endmodule

// File: tb/tb_dma_descriptor_queue.sv
// Scoreboard bench for dma_descriptor_queue: expected descriptors queued at push, matched against observed launches.
module tb_dma_descriptor_queue;
    localparam int QDEPTH    = 4;
    localparam int MODE_OK   = 0;
    localparam int MODE_ERR  = 1;
    localparam int MODE_NONE = 2;

    typedef struct packed {
        logic [31:0] t;
        logic [19:0] r;
        logic [9:0]  l;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] target_begin_address;
    logic [19:0] rd_address;
    logic [9:0]  transfer_length;
    logic        begin_dma, abort_dma, irq_o;
    logic        dma_active, dma_complete_ok, dma_err;

    int   vectors = 0;
    int   miscompares = 0;
    int   eng_mode = MODE_OK;
    int   eng_len = 20;
    int   eng_cnt;
    int   launches = 0;
    int   aborts = 0;
    int   width_err = 0;
    int   obs_rd = 0;
    logic prev_begin = 1'b0;
    logic prev_abort = 1'b0;
    int   ack_lat;
    exp_t sb[$];
    exp_t obs[$];

    dma_descriptor_queue_if bus();

    dma_descriptor_queue #(.QDEPTH(QDEPTH)) dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .wbs                  (bus),
        .target_begin_address (target_begin_address),
        .rd_address           (rd_address),
        .transfer_length      (transfer_length),
        .begin_dma            (begin_dma),
        .abort_dma            (abort_dma),
        .dma_active           (dma_active),
        .dma_complete_ok      (dma_complete_ok),
        .dma_err              (dma_err),
        .irq_o                (irq_o)
    );

    always #5 clk_i = ~clk_i;

    // Downstream engine model: active for eng_len cycles after each launch, then reports per eng_mode.
    initial begin
        dma_active = 1'b0;
        dma_complete_ok = 1'b0;
        dma_err = 1'b0;
        eng_cnt = 0;
        forever begin
            @(posedge clk_i); #1;
            if (rst_i || abort_dma) begin
                dma_active = 1'b0;
                eng_cnt = 0;
            end else if (begin_dma) begin
                dma_complete_ok = 1'b0;
                dma_err = 1'b0;
                if (eng_mode != MODE_NONE) begin
                    dma_active = 1'b1;
                    eng_cnt = eng_len;
                end
            end else if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    dma_active = 1'b0;
                    dma_complete_ok = (eng_mode == MODE_OK);
                    dma_err = (eng_mode == MODE_ERR);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (begin_dma) begin
                    obs.push_back({target_begin_address, rd_address, transfer_length});
                    launches++;
                    if (prev_begin) width_err++;
                end
                if (abort_dma) begin
                    aborts++;
                    if (prev_abort) width_err++;
                end
            end
            prev_begin = begin_dma;
            prev_abort = abort_dma;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic wb_access(input logic we, input logic [3:0] a, input logic [31:0] d, output logic [31:0] q);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = a;
        bus.wbs_dat_i = d;
        ack_lat = 0;
        do begin
            @(posedge clk_i); #1;
            ack_lat++;
        end while (!bus.wbs_ack_o && ack_lat < 8);
        q = bus.wbs_dat_o;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        if (!bus.wbs_ack_o) begin
            vectors++;
            miscompares++;
            $display("FAIL wb_ack_timeout: adr %h got no ack, required ack", a);
        end
    endtask

    task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] q;
        wb_access(1'b1, a, d, q);
    endtask

    task automatic wb_read(input logic [3:0] a, output logic [31:0] q);
        wb_access(1'b0, a, 32'h0, q);
    endtask

    task automatic wait_status(input logic [31:0] mask, input logic [31:0] val, output logic ok);
        logic [31:0] d;
        ok = 1'b0;
        for (int i = 0; i < 150; i++) begin
            wb_read(4'hC, d);
            if ((d & mask) == val) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic push_desc(input logic [31:0] t, input logic [31:0] r, input logic [9:0] l, input bit expect_accept);
        wb_write(4'h0, t);
        wb_write(4'h4, r);
        wb_write(4'h8, {22'h0, l});
        if (expect_accept) sb.push_back({t, r[19:0], l});
    endtask

    task automatic drain(input string name);
        exp_t e;
        while (obs_rd < obs.size()) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL %s_unexpected_launch: got %h, required none", name, obs[obs_rd]);
            end else begin
                e = sb.pop_front();
                if (obs[obs_rd] !== e) begin
                    miscompares++;
                    $display("FAIL %s_descriptor: got %h, required %h", name, obs[obs_rd], e);
                end
            end
            obs_rd++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        vectors++;
        if ({begin_dma, abort_dma, irq_o, bus.wbs_ack_o, target_begin_address, rd_address, transfer_length} !== 66'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {begin_dma, abort_dma, irq_o, bus.wbs_ack_o, target_begin_address, rd_address, transfer_length});
        end
        rst_i = 1'b0;
        wb_read(4'hC, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL reset_status: got %h, required 0", d); end
        vectors++;
        if (ack_lat !== 1) begin miscompares++; $display("FAIL ack_latency: got %0d, required 1", ack_lat); end
        @(posedge clk_i); #1;
        vectors++;
        if ({bus.wbs_ack_o, bus.wbs_err_o, bus.wbs_rty_o} !== 3'b000) begin
            miscompares++;
            $display("FAIL ack_width: ack/err/rty %b, required 000", {bus.wbs_ack_o, bus.wbs_err_o, bus.wbs_rty_o});
        end
    endtask

    task automatic test_single();
        logic [31:0] d;
        logic ok;
        int l0;
        eng_mode = MODE_OK;
        eng_len = 20;
        l0 = launches;
        push_desc(32'h1000_0000, 32'hFFF0_0040, 10'd15, 1'b1);
        wb_read(4'h4, d);
        vectors++;
        if (d !== 32'h0000_0040) begin miscompares++; $display("FAIL rdaddr_readback: got %h, required 00000040", d); end
        wb_read(4'h8, d);
        vectors++;
        if (d !== 32'd15) begin miscompares++; $display("FAIL len_readback: got %h, required 0000000f", d); end
        wb_write(4'hC, 32'h5);
        wait_status(32'h00FF_011F, 32'h0001_0000, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL single_done: completion not seen, required done=1 idle"); end
        vectors++;
        if (launches - l0 !== 1) begin miscompares++; $display("FAIL single_launches: got %0d, required 1", launches - l0); end
        drain("single");
        wb_read(4'hC, d);
        vectors++;
        if (d !== 32'h0001_1800) begin miscompares++; $display("FAIL single_status: got %h, required 00011800", d); end
        vectors++;
        if (irq_o !== 1'b1) begin miscompares++; $display("FAIL single_irq: got %b, required 1", irq_o); end
        wb_write(4'hC, 32'h8);
        wb_read(4'hC, d);
        vectors++;
        if ({irq_o, d} !== 33'h0) begin miscompares++; $display("FAIL clear_status: irq %b status %h, required 0 0", irq_o, d); end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic ok;
        int l0;
        for (int i = 0; i < 5; i++) begin
            push_desc(32'h2000_0000 + 32'(i * 16), 32'(i * 4 + 1), 10'(i + 3), i < QDEPTH);
        end
        wb_read(4'hC, d);
        vectors++;
        if (d !== 32'h0000_0404) begin miscompares++; $display("FAIL overflow_status: got %h, required 00000404", d); end
        l0 = launches;
        wb_write(4'hC, 32'h1);
        wait_status(32'h00FF_011F, 32'h0004_0000, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL overflow_done: 4 completions not seen, required 4"); end
        vectors++;
        if (launches - l0 !== 4) begin miscompares++; $display("FAIL overflow_launches: got %0d, required 4", launches - l0); end
        drain("overflow");
        wb_read(4'hC, d);
        vectors++;
        if ({irq_o, d} !== {1'b0, 32'h0004_0C00}) begin
            miscompares++;
            $display("FAIL overflow_final: irq %b status %h, required 0 00040c00", irq_o, d);
        end
        wb_write(4'hC, 32'h8);
    endtask

    task automatic test_error();
        logic [31:0] d;
        logic ok;
        eng_mode = MODE_ERR;
        for (int i = 0; i < 3; i++) begin
            push_desc(32'h3000_0100 + 32'(i), 32'h0_0200 + 32'(i), 10'(100 + i), 1'b1);
        end
        wb_write(4'hC, 32'h5);
        wait_status(32'h0000_0300, 32'h0000_0200, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL error_halt: error sticky not seen, required 1"); end
        drain("error");
        wb_read(4'hC, d);
        vectors++;
        if (d !== 32'h0000_1202) begin miscompares++; $display("FAIL error_status: got %h, required 00001202", d); end
        vectors++;
        if (irq_o !== 1'b1) begin miscompares++; $display("FAIL error_irq: got %b, required 1", irq_o); end
        eng_mode = MODE_OK;
        wb_write(4'hC, 32'hD);
        wait_status(32'h00FF_011F, 32'h0002_0000, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL error_resume: 2 completions not seen, required 2"); end
        drain("resume");
        vectors++;
        if (sb.size() !== 0) begin miscompares++; $display("FAIL resume_pending: %0d left, required 0", sb.size()); end
        wb_read(4'hC, d);
        vectors++;
        if (d !== 32'h0002_1800) begin miscompares++; $display("FAIL resume_status: got %h, required 00021800", d); end
        wb_write(4'hC, 32'h8);
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        bit found;
        int n;
        eng_mode = MODE_NONE;
        push_desc(32'h4000_0000, 32'h0_0777, 10'd1, 1'b1);
        wb_write(4'hC, 32'h5);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (begin_dma) begin found = 1; break; end
        end
        n = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk_i);
            if (irq_o) begin n = i; break; end
        end
        vectors++;
        if (!found || n !== 5) begin
            miscompares++;
            $display("FAIL timeout_cycles: launch seen %0d, error after %0d cycles, required 1 and 5", found, n);
        end
        @(posedge clk_i); #1;
        drain("timeout");
        wb_read(4'hC, d);
        vectors++;
        if (d !== 32'h0000_1A00) begin miscompares++; $display("FAIL timeout_status: got %h, required 00001a00", d); end
        wb_write(4'hC, 32'h8);
        wb_read(4'hC, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL halt_clear: got %h, required 0", d); end
    endtask

    task automatic test_abort();
        logic [31:0] d;
        logic ok;
        int l0, a0;
        eng_mode = MODE_OK;
        eng_len = 20;
        for (int i = 0; i < 4; i++) begin
            push_desc(32'h5000_0000 + 32'(i * 256), 32'h0_1000 + 32'(i), 10'(i * 7), 1'b1);
        end
        l0 = launches;
        a0 = aborts;
        wb_write(4'hC, 32'h1);
        wait_status(32'h0000_011F, 32'h0000_0103, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL abort_setup: busy with 3 queued not seen, required it"); end
        repeat (4) @(posedge clk_i);
        #1;
        wb_write(4'hC, 32'h3);
        drain("abort");
        sb.delete();
        repeat (60) @(posedge clk_i);
        #1;
        vectors++;
        if (aborts - a0 !== 1) begin miscompares++; $display("FAIL abort_pulses: got %0d, required 1", aborts - a0); end
        vectors++;
        if (launches - l0 !== 1) begin miscompares++; $display("FAIL abort_launches: got %0d, required 1", launches - l0); end
        wb_read(4'hC, d);
        vectors++;
        if (d !== 32'h0000_0800) begin miscompares++; $display("FAIL abort_status: got %h, required 00000800", d); end
        wb_write(4'hC, 32'h8);
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic ok;
        int a0;
        eng_mode = MODE_OK;
        push_desc(32'hCAFE_0000, 32'h1_2345, 10'd7, 1'b1);
        push_desc(32'hCAFE_0004, 32'h1_2349, 10'd9, 1'b1);
        wb_write(4'hC, 32'h5);
        wait_status(32'h0000_011F, 32'h0000_0101, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL rstmid_setup: busy with 1 queued not seen, required it"); end
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        vectors++;
        if ({target_begin_address, rd_address, transfer_length} !== {32'hCAFE_0000, 20'h1_2345, 10'd7}) begin
            miscompares++;
            $display("FAIL rstmid_desc: got %h, required %h", {target_begin_address, rd_address, transfer_length},
                     {32'hCAFE_0000, 20'h1_2345, 10'd7});
        end
        drain("rstmid");
        a0 = aborts;
        rst_i = 1'b1;
        #1;
        vectors++;
        if ({begin_dma, abort_dma, irq_o, bus.wbs_ack_o, target_begin_address, rd_address, transfer_length} !== 66'd0) begin
            miscompares++;
            $display("FAIL rstmid_async: got %h, required 0",
                     {begin_dma, abort_dma, irq_o, bus.wbs_ack_o, target_begin_address, rd_address, transfer_length});
        end
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk_i);
        #1;
        wb_read(4'hC, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL rstmid_status: got %h, required 0", d); end
        vectors++;
        if (aborts !== a0) begin miscompares++; $display("FAIL rstmid_abort: %0d pulses, required 0", aborts - a0); end
    endtask

    initial begin
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = 4'h0;
        bus.wbs_dat_i = 32'h0;
        test_reset();
        test_single();
        test_overflow();
        test_error();
        test_timeout();
        test_abort();
        test_reset_mid();
        vectors++;
        if (width_err !== 0) begin miscompares++; $display("FAIL pulse_width: %0d long pulses, required 0", width_err); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
